// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer.
// Applies execute redirects and squashes wrong-path responses before decode.
module fetch_ctrl #(
    parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        drop_q, drop_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [63:0] target;
    logic        hs_now, wait_open;

    assign target         = redirect_pc & ~64'h3;
    assign hs_now         = (state_q == REQ) && imem_req_ready;
    assign wait_open      = (state_q == WAIT) && !imem_resp_valid;
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign out_valid      = (state_q == HOLD);
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        if (redirect_valid) begin
            // An issued request that cannot be recalled must have its response dropped.
            fetch_pc_d = target;
            state_d    = (hs_now || wait_open) ? WAIT : REQ;
            drop_d     = hs_now || wait_open;
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ:  state_d = imem_req_ready ? WAIT : REQ;
                WAIT: if (imem_resp_valid) begin
                    state_d = drop_q ? REQ : HOLD;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        out_pc_d   = fetch_pc_q;
                        out_inst_d = imem_resp_data;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                end
                default: state_d = out_ready ? REQ : HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_START;
            drop_q     <= 1'b0;
            out_pc_q   <= 64'd0;
            out_inst_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table plus hand sequences against a latency-programmable memory model.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        out_ready = 1'b1;
    logic        imem_req_valid, out_valid;
    logic [63:0] imem_req_addr, out_pc;
    logic [31:0] out_inst;
    logic        d2_rv, d2_ov;
    logic [63:0] d2_addr, d2_pc;
    logic [31:0] d2_inst;
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    fetch_ctrl #(.PC_START(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(d2_rv), .imem_req_ready(imem_req_ready), .imem_req_addr(d2_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(d2_ov), .out_ready(out_ready), .out_pc(d2_pc), .out_inst(d2_inst)
    );

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    // Memory model: looks at the handshake just before the edge, answers lat cycles later.
    initial begin
        bit          pend = 0;
        int          cnt = 0;
        logic [63:0] paddr = 64'd0;
        forever begin
            @(negedge clk);
            #2;
            imem_resp_valid = 1'b0;
            if (!rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = memf(paddr);
                        pend = 0;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend = 1;
                    cnt = lat;
                    paddr = imem_req_addr;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_sig(input bit want_ov, input bit no_ov, input string nm);
        int n = 0;
        while (!(want_ov ? out_valid : imem_req_valid) && n < 20) begin
            if (no_ov) chk({nm, "_no_ov"}, 64'(out_valid), 64'd0);
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < 20), 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rr;
        logic        orr;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 64'h8000_0000, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 64'h8000_0004, 1'b1, 64'h8000_0000};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h8000_0000};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 64'h8000_0004, 1'b0, 64'h8000_0000};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 64'h8000_0008, 1'b1, 64'h8000_0004};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b0, 64'h8000_0004};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 64'h8000_0008, 1'b0, 64'h8000_0004};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 64'h8000_000C, 1'b1, 64'h8000_0008};

        tick();
        chk("rst_rv", 64'(imem_req_valid), 64'd0);
        chk("rst_addr", imem_req_addr, 64'h8000_0000);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_inst", 64'(out_inst), 64'd0);
        chk("rst_addr2", d2_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        rst = 1'b1;

        // Back-to-back fetches with 1-cycle memory and an always-ready decode.
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("seq%0d_rv", k), 64'(imem_req_valid), 64'(tbl[k].exp_rv));
            chk($sformatf("seq%0d_addr", k), imem_req_addr, tbl[k].exp_addr);
            chk($sformatf("seq%0d_ov", k), 64'(out_valid), 64'(tbl[k].exp_ov));
            chk($sformatf("seq%0d_pc", k), out_pc, tbl[k].exp_pc);
            if (tbl[k].exp_ov) chk($sformatf("seq%0d_inst", k), 64'(out_inst), 64'(memf(tbl[k].exp_pc)));
            if (k == 0) chk("wrap_first", d2_addr, 64'hFFFF_FFFF_FFFF_FFFC);
            if (k == 2) begin
                chk("wrap_ov", 64'(d2_ov), 64'd1);
                chk("wrap_pc", d2_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("wrap_inst", 64'(d2_inst), 64'h8000_0013);
            end
            if (k == 3) begin
                chk("wrap_rv", 64'(d2_rv), 64'd1);
                chk("wrap_addr", d2_addr, 64'd0);
            end
            imem_req_ready = tbl[k].rr;
            out_ready = tbl[k].orr;
        end

        // Decode backpressure holds the instruction.
        out_ready = 1'b0;
        do_reset();
        wait_sig(1'b1, 1'b0, "bp_wait");
        chk("bp_pc0", out_pc, 64'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ov", 64'(out_valid), 64'd1);
            chk("bp_pc", out_pc, 64'h8000_0000);
            chk("bp_inst", 64'(out_inst), 64'(memf(64'h8000_0000)));
            chk("bp_rv", 64'(imem_req_valid), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_ov", 64'(out_valid), 64'd0);
        chk("bp_rel_rv", 64'(imem_req_valid), 64'd1);
        chk("bp_rel_addr", imem_req_addr, 64'h8000_0004);

        // Redirect while waiting on a slow response.
        lat = 3;
        do_reset();
        wait_sig(1'b0, 1'b0, "rw_req");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        wait_sig(1'b0, 1'b1, "rw_next");
        chk("rw_addr", imem_req_addr, 64'h8000_1000);
        wait_sig(1'b1, 1'b0, "rw_ov");
        chk("rw_pc", out_pc, 64'h8000_1000);
        chk("rw_inst", 64'(out_inst), 64'(memf(64'h8000_1000)));

        // Redirect coincident with the request handshake.
        lat = 1;
        do_reset();
        wait_sig(1'b0, 1'b0, "rh_req");
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2002;
        tick();
        redirect_valid = 1'b0;
        chk("rh_wait_rv", 64'(imem_req_valid), 64'd0);
        wait_sig(1'b0, 1'b1, "rh_next");
        chk("rh_addr", imem_req_addr, 64'h8000_2000);
        wait_sig(1'b1, 1'b0, "rh_ov");
        chk("rh_pc", out_pc, 64'h8000_2000);

        // Redirect coincident with the response.
        do_reset();
        wait_sig(1'b0, 1'b0, "rr_req");
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2002;
        tick();
        redirect_valid = 1'b0;
        chk("rr_ov", 64'(out_valid), 64'd0);
        chk("rr_rv", 64'(imem_req_valid), 64'd1);
        chk("rr_addr", imem_req_addr, 64'h8000_2000);
        wait_sig(1'b1, 1'b0, "rr_ovw");
        chk("rr_pc", out_pc, 64'h8000_2000);
        chk("rr_inst", 64'(out_inst), 64'(memf(64'h8000_2000)));

        // Redirect in HOLD squashes the held instruction even with out_ready.
        out_ready = 1'b0;
        do_reset();
        wait_sig(1'b1, 1'b0, "rd_hold");
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        chk("rd_ov", 64'(out_valid), 64'd0);
        chk("rd_rv", 64'(imem_req_valid), 64'd1);
        chk("rd_addr", imem_req_addr, 64'h8000_3000);
        wait_sig(1'b1, 1'b0, "rd_ovw");
        chk("rd_pc", out_pc, 64'h8000_3000);

        // Redirect in REQ without handshake retargets the pending request.
        imem_req_ready = 1'b0;
        do_reset();
        wait_sig(1'b0, 1'b0, "rq_req");
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        chk("rq_rv", 64'(imem_req_valid), 64'd1);
        chk("rq_addr", imem_req_addr, 64'h8000_4000);
        imem_req_ready = 1'b1;

        // Asynchronous reset while a response is outstanding.
        do_reset();
        wait_sig(1'b1, 1'b0, "ar_first");
        lat = 3;
        tick();
        tick();
        chk("ar_in_wait", 64'(imem_req_valid | out_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("ar_rv", 64'(imem_req_valid), 64'd0);
        chk("ar_ov", 64'(out_valid), 64'd0);
        chk("ar_addr", imem_req_addr, 64'h8000_0000);
        chk("ar_pc", out_pc, 64'd0);
        chk("ar_inst", 64'(out_inst), 64'd0);
        lat = 1;
        tick();
        rst = 1'b1;
        wait_sig(1'b0, 1'b1, "ar_restart");
        chk("ar_re_addr", imem_req_addr, 64'h8000_0000);
        wait_sig(1'b1, 1'b0, "ar_re_ov");
        chk("ar_re_pc", out_pc, 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
